// File: rtl/spk_in_dispatch.sv
// Spike-input dispatcher: buffers router flits in a small FIFO and steers each
// head flit to the axon path or config_ctrl, dropping invalid types.
module spk_in_dispatch #(
    parameter int FW    = 59,
    parameter int FTW   = 3,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          router_spk_in_we,
    input  logic [FW-1:0] router_spk_in_wdata,
    output logic          spk_in_router_credit,
    output logic          spk_in_config_we,
    output logic [FW-1:0] spk_in_config_wdata,
    input  logic          config_spk_in_credit,
    output logic          spk_in_axon_we,
    output logic [FW-1:0] spk_in_axon_wdata,
    input  logic          axon_spk_in_full,
    output logic [AW:0]   fifo_count,
    output logic          overflow_err
);
    logic [FW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           cfg_token;
    logic [FW-1:0]  head;
    logic [FTW-1:0] head_type;
    logic           is_axon, is_cfg;
    logic           full, push, pop, cfg_issue, axon_issue;

    assign head      = mem[rd_ptr];
    assign head_type = head[FW-1:FW-FTW];

    always_comb begin
        is_axon = (head_type == FTW'(0)) || (head_type == FTW'(1)) || (head_type == FTW'(2));
        is_cfg  = (head_type == FTW'(6)) || (head_type == FTW'(7));
    end

    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign full       = (count == (AW+1)'(DEPTH));
    assign push       = router_spk_in_we && !full;
    assign pop        = (count != '0) &&
                        (is_axon ? !axon_spk_in_full : (is_cfg ? cfg_token : 1'b1));
    assign cfg_issue  = pop && is_cfg;
    assign axon_issue = pop && is_axon;
    assign fifo_count = count;

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= router_spk_in_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cfg_token    <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            cfg_token <= (cfg_token && !cfg_issue) || config_spk_in_credit;
            if (router_spk_in_we && full) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_in_router_credit <= 1'b0;
            spk_in_config_we     <= 1'b0;
            spk_in_axon_we       <= 1'b0;
            spk_in_config_wdata  <= '0;
            spk_in_axon_wdata    <= '0;
        end else begin
            spk_in_router_credit <= pop;
            spk_in_config_we     <= cfg_issue;
            spk_in_axon_we       <= axon_issue;
            if (cfg_issue)  spk_in_config_wdata <= head;
            if (axon_issue) spk_in_axon_wdata   <= head;
        end
    end
endmodule

// File: doc/spk_in_dispatch.md
SPK_IN_DISPATCH -- requirements
Module: spk_in_dispatch

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- FW, 59, flit width
- FTW, 3, flit type width
- DEPTH, 4, ingress FIFO entries (power of 2, at least 2)
- AW, 2, log2(DEPTH)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock
- rst_n, in, 1, asynchronous active-low reset
- router_spk_in_we, in, 1, flit write strobe from router
- router_spk_in_wdata, in, FW, flit from router
- spk_in_router_credit, out, 1, one-cycle pulse per FIFO entry released
- spk_in_config_we, out, 1, flit strobe to config_ctrl
- spk_in_config_wdata, out, FW, flit to config_ctrl
- config_spk_in_credit, in, 1, config_ctrl has finished one flit
- spk_in_axon_we, out, 1, flit strobe to axon path
- spk_in_axon_wdata, out, FW, flit to axon path
- axon_spk_in_full, in, 1, axon path cannot accept
- fifo_count, out, AW+1, current FIFO occupancy
- overflow_err, out, 1, sticky flag: a push was attempted while full

Function
REQ-003 The flit type SHALL be bits [FW-1:FW-FTW] of the flit.
- SPIKE=000, DATA=001, DATA_END=010: routed to axon.
- WRITE=110, READ=111: routed to config.
- 011, 100, 101: invalid.
REQ-004 Push: router_spk_in_we with count<DEPTH SHALL write the flit at wr_ptr and advance wr_ptr modulo DEPTH.
REQ-005 Push with count==DEPTH (registered count) SHALL be discarded and SHALL set overflow_err, even if a pop occurs in the same cycle.
REQ-006 cfg_token SHALL be a 1-bit register, reset to 1.
- Next value = (cfg_token AND NOT cfg_issue) OR config_spk_in_credit.
- A credit arriving while cfg_token=1 SHALL leave it at 1, with no count-up.
REQ-007 Pop SHALL occur only when count>0, in strict FIFO order with head-of-line blocking. Eligibility of the head entry:
- axon class: NOT axon_spk_in_full.
- config class: cfg_token==1 (this pop is cfg_issue).
- invalid class: always eligible, dropped, no output strobe.
REQ-008 On a pop, the head flit SHALL be registered into the selected wdata output, and the matching we SHALL pulse high for exactly the next cycle.
- The non-selected wdata output SHALL hold its previous value.
- At most one pop SHALL occur per cycle.
REQ-009 spk_in_router_credit SHALL pulse high in the cycle after every pop, including invalid-type drops, and SHALL never pulse for a rejected push.
REQ-010 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
- Push into an empty FIFO SHALL not pop in the same cycle.
- Minimum latency is push at cycle N, pop at N+1, we and credit high at N+2.
REQ-011 count SHALL be a registered AW+1-bit counter driven to fifo_count. Pointers SHALL wrap from DEPTH-1 to 0.
REQ-012 A config-class head with cfg_token==0 SHALL stall the whole FIFO, including axon flits behind it, until a credit arrives.
- The pop SHALL occur no earlier than the cycle after the credit.

Reset
REQ-013 While rst_n is low, the block SHALL clear the following immediately and asynchronously:
- wr_ptr, rd_ptr, count = 0.
- cfg_token = 1.
- overflow_err = 0.
- All we and credit outputs = 0.
- Both wdata outputs = 0.
REQ-014 Reset asserted mid-operation SHALL discard all FIFO contents without issuing credits. The first push after reset release SHALL be accepted normally.

Verification
REQ-015 Single WRITE flit (type 110, addr 0x1234) pushed at cycle 0:
- spk_in_config_we=1 at cycle 2 with identical wdata.
- spk_in_router_credit=1 at cycle 2.
- fifo_count back to 0.
REQ-016 Two READ flits pushed back-to-back, no config credit:
- First delivered.
- Second held, fifo_count=1.
- config_spk_in_credit at cycle 10 gives second spk_in_config_we at cycle 12.
REQ-017 Config-blocked head followed by a SPIKE flit: no spk_in_axon_we until the config credit. Order is preserved: config flit first, spike one cycle later.
REQ-018 axon_spk_in_full=1 with 4 SPIKE flits pushed, then a 5th push:
- fifo_count=4.
- overflow_err=1.
- After full drops, 4 axon strobes on consecutive cycles with credits.
REQ-019 Type 100 flit pushed: no we on either output, one router credit pulse, count returns to 0.
REQ-020 rst_n pulsed low with 3 entries queued:
- count=0, cfg_token=1, no credit pulses.
- Next WRITE push delivered at push+2.
